mux_4_1_8_bit_arbiter_v: RTL

MUX_4_1_8_BIT_ARBITER_V -- requirements
Module: mux_4_1_8_bit_arbiter_v

---
 rtl/mux_4_1_8_bit_arbiter_v.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mux_4_1_8_bit_arbiter_v.sv
// Round-robin 4-requester arbiter driving an 8-bit 4:1 mux; registered outputs, one IDLE cycle per arbitration.
// Optional per-grant beat limit compiled with macro RR_ARB_BURST_LIMIT_EN (BURST_MAX beats, legal 1..15).
module mux_4_1_8_bit_arbiter_v #(
  parameter int BURST_MAX = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic [3:0] i_last,
  input  logic [7:0] i_code_0,
  input  logic [7:0] i_code_1,
  input  logic [7:0] i_code_2,
  input  logic [7:0] i_code_3,
  output logic [3:0] o_gnt,
  output logic [1:0] o_sel_code,
  output logic       o_en,
  output logic [7:0] o_code,
  output logic       o_valid
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst_max
    $error("BURST_MAX must be in 1..15");
  end

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] sel_nxt;
  logic       en_nxt;
  logic [7:0] code_nxt;
  logic       valid_nxt;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic [7:0] code_g;
  logic       xfer;
  logic       release_g;
`ifdef RR_ARB_BURST_LIMIT_EN
  logic [3:0] beat_cnt, beat_cnt_nxt;
`endif

  // Search starts just past the last granted index so every requester gets a turn.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && i_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    case (o_sel_code)
      2'd0:    code_g = i_code_0;
      2'd1:    code_g = i_code_1;
      2'd2:    code_g = i_code_2;
      default: code_g = i_code_3;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = o_gnt;
    sel_nxt   = o_sel_code;
    en_nxt    = o_en;
    code_nxt  = 8'h00;
    valid_nxt = 1'b0;
    xfer      = 1'b0;
    release_g = 1'b0;
`ifdef RR_ARB_BURST_LIMIT_EN
    beat_cnt_nxt = beat_cnt;
`endif
    case (state)
      IDLE: begin
        if (|i_req) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << winner;
          sel_nxt   = winner;
          en_nxt    = 1'b1;
        end
      end
      GRANT: begin
        xfer      = i_req[o_sel_code];
        release_g = !xfer || i_last[o_sel_code];
        if (xfer) begin
          code_nxt  = code_g;
          valid_nxt = 1'b1;
        end
`ifdef RR_ARB_BURST_LIMIT_EN
        if (xfer) begin
          beat_cnt_nxt = beat_cnt + 4'd1;
          if (beat_cnt + 4'd1 == 4'(BURST_MAX)) release_g = 1'b1;
        end
`endif
        if (release_g) begin
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
          en_nxt    = 1'b0;
          ptr_nxt   = o_sel_code;
`ifdef RR_ARB_BURST_LIMIT_EN
          beat_cnt_nxt = 4'd0;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ptr resets to 3 so requester 0 is searched first after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      ptr        <= 2'd3;
      o_gnt      <= 4'b0000;
      o_sel_code <= 2'd0;
      o_en       <= 1'b0;
      o_code     <= 8'h00;
      o_valid    <= 1'b0;
`ifdef RR_ARB_BURST_LIMIT_EN
      beat_cnt   <= 4'd0;
`endif
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      o_gnt      <= gnt_nxt;
      o_sel_code <= sel_nxt;
      o_en       <= en_nxt;
      o_code     <= code_nxt;
      o_valid    <= valid_nxt;
`ifdef RR_ARB_BURST_LIMIT_EN
      beat_cnt   <= beat_cnt_nxt;
`endif
    end
  end

endmodule
